uart_rx_framed: RTL and testbench

Parametrised UART receiver and successor to the fixed 8N1 receiver. It supports configurable data width, optional odd/even parity, one or two stop bits, an input synchroniser and start-bit glitch rejection. It reports parity and framing errors alongside each received word. It sits between a GPIO rx pin and byte-consuming logic such as display registers or record parsers.

---
 rtl/uart_rx_framed.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_framed.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_framed.sv
// uart_rx_framed: parametrised UART receiver with optional parity,
// one or two stop bits, input synchroniser and start-glitch rejection.
module uart_rx_framed #(
    parameter int clock_frequency = 50000000,
    parameter int baud_rate       = 115200,
    parameter int data_bits       = 8,
    parameter int parity_mode     = 0,
    parameter int stop_bits       = 1,
    parameter int sync_stages     = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    output logic [data_bits-1:0] byte_data,
    output logic                 byte_ready,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 busy
);
    localparam int CPB  = clock_frequency / baud_rate;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state;
    state_t               state_n;
    logic [sync_stages-1:0] sync_q;
    logic                 rx_s;
    logic                 rx_p;
    logic                 start_edge;
    logic                 strobe;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        load_val;
    logic                 load;
    logic                 shift;
    logic                 par_chk;
    logic                 stop_chk;
    logic                 done;
    logic                 frame_start;
    logic                 bit_clr;
    logic                 bit_inc;
    logic [3:0]           bit_cnt;
    logic [data_bits-1:0] shreg;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 par_x;

    assign rx_s       = sync_q[sync_stages-1];
    assign start_edge = rx_p & ~rx_s;
    assign strobe     = (cnt == CW'(1));
    assign busy       = (state != IDLE);
    assign par_x      = (^shreg) ^ rx_s;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '1;
            rx_p   <= 1'b1;
        end else begin
            sync_q <= {sync_q[sync_stages-2:0], rx};
            rx_p   <= rx_s;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n     = state;
        load        = 1'b0;
        load_val    = CW'(CPB);
        shift       = 1'b0;
        par_chk     = 1'b0;
        stop_chk    = 1'b0;
        done        = 1'b0;
        frame_start = 1'b0;
        bit_clr     = 1'b0;
        bit_inc     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_edge) begin
                    load     = 1'b1;
                    load_val = CW'(HALF);
                    state_n  = START;
                end
            end
            START: begin
                if (strobe) begin
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        load        = 1'b1;
                        frame_start = 1'b1;
                        bit_clr     = 1'b1;
                        state_n     = DATA;
                    end
                end
            end
            DATA: begin
                if (strobe) begin
                    load  = 1'b1;
                    shift = 1'b1;
                    if (bit_cnt == 4'(data_bits - 1)) begin
                        bit_clr = 1'b1;
                        state_n = (parity_mode != 0) ? PARITY : STOP;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (strobe) begin
                    load    = 1'b1;
                    par_chk = 1'b1;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (strobe) begin
                    stop_chk = 1'b1;
                    if (bit_cnt == 4'(stop_bits - 1)) begin
                        done    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        load    = 1'b1;
                        bit_inc = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Loads happen only at an edge or a strobe, so the counter never wraps.
    always_ff @(posedge clock) begin
        if (reset)           cnt <= '0;
        else if (load)       cnt <= load_val;
        else if (cnt != '0)  cnt <= cnt - CW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt <= '0;
            shreg   <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            if (bit_clr)      bit_cnt <= '0;
            else if (bit_inc) bit_cnt <= bit_cnt + 4'd1;
            if (shift) shreg <= {rx_s, shreg[data_bits-1:1]};
            if (par_chk) perr_q <= (parity_mode == 2) ? par_x : ~par_x;
            if (frame_start)          ferr_q <= 1'b0;
            else if (stop_chk & ~rx_s) ferr_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_data     <= '0;
            byte_ready    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            byte_ready <= done;
            if (done) begin
                byte_data     <= shreg;
                parity_error  <= perr_q;
                framing_error <= ferr_q | ~rx_s;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: three instances (8N1, 8E1, 7O2) at cpb = 16,
// bit-accurate frames checked against a frame-level reference model.
module tb_uart_rx_framed;
    localparam int CPB = 16;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_a = 1'b1, reset_b = 1'b1, reset_c = 1'b1;
    logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
    logic [7:0] data_a, data_b;
    logic [6:0] data_c;
    logic rdy_a, rdy_b, rdy_c;
    logic pe_a, pe_b, pe_c;
    logic fe_a, fe_b, fe_c;
    logic busy_a, busy_b, busy_c;

    int checks = 0;
    int errors = 0;

    uart_rx_framed #(.clock_frequency(1600), .baud_rate(100), .data_bits(8),
        .parity_mode(0), .stop_bits(1), .sync_stages(2)) u_a (
        .clock(clock), .reset(reset_a), .rx(rx_a), .byte_data(data_a),
        .byte_ready(rdy_a), .parity_error(pe_a), .framing_error(fe_a),
        .busy(busy_a));

    uart_rx_framed #(.clock_frequency(1600), .baud_rate(100), .data_bits(8),
        .parity_mode(2), .stop_bits(1), .sync_stages(2)) u_b (
        .clock(clock), .reset(reset_b), .rx(rx_b), .byte_data(data_b),
        .byte_ready(rdy_b), .parity_error(pe_b), .framing_error(fe_b),
        .busy(busy_b));

    uart_rx_framed #(.clock_frequency(1600), .baud_rate(100), .data_bits(7),
        .parity_mode(1), .stop_bits(2), .sync_stages(3)) u_c (
        .clock(clock), .reset(reset_c), .rx(rx_c), .byte_data(data_c),
        .byte_ready(rdy_c), .parity_error(pe_c), .framing_error(fe_c),
        .busy(busy_c));

    typedef struct {
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       busy;
        logic       busy_prev;
        int         cyc;
    } rec_t;

    typedef struct {
        logic [8:0] data;
        logic       pe;
        logic       fe;
    } exp_t;

    rec_t q_a[$], q_b[$], q_c[$];
    int   cyc = 0;
    logic bp_a = 1'b0, bp_b = 1'b0, bp_c = 1'b0;

    always @(negedge clock) begin
        cyc++;
        if (rdy_a) q_a.push_back('{9'(data_a), pe_a, fe_a, busy_a, bp_a, cyc});
        if (rdy_b) q_b.push_back('{9'(data_b), pe_b, fe_b, busy_b, bp_b, cyc});
        if (rdy_c) q_c.push_back('{9'(data_c), pe_c, fe_c, busy_c, bp_c, cyc});
        bp_a = busy_a;
        bp_b = busy_b;
        bp_c = busy_c;
    end

    function automatic int nb(input int w);
        return (w == 2) ? 7 : 8;
    endfunction

    function automatic int pm(input int w);
        case (w)
            0: return 0;
            1: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int ns(input int w);
        return (w == 2) ? 2 : 1;
    endfunction

    function automatic int qsize(input int w);
        case (w)
            0: return q_a.size();
            1: return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    function automatic rec_t pop(input int w);
        rec_t r = '{default: '0};
        case (w)
            0: if (q_a.size() > 0) r = q_a.pop_front();
            1: if (q_b.size() > 0) r = q_b.pop_front();
            default: if (q_c.size() > 0) r = q_c.pop_front();
        endcase
        return r;
    endfunction

    function automatic void clear_q(input int w);
        case (w)
            0: q_a.delete();
            1: q_b.delete();
            default: q_c.delete();
        endcase
    endfunction

    // Reference model: parity and framing judged on the frame as sent.
    function automatic int ones(input int w, input logic [8:0] d);
        int n = 0;
        for (int i = 0; i < nb(w); i++) n += int'(d[i]);
        return n;
    endfunction

    function automatic logic good_pbit(input int w, input logic [8:0] d);
        if (pm(w) == 2) return logic'(ones(w, d) % 2);
        return logic'((ones(w, d) + 1) % 2);
    endfunction

    function automatic logic ref_pe(input int w, input logic [8:0] d,
                                    input logic pb);
        int total = ones(w, d) + int'(pb);
        if (pm(w) == 0) return 1'b0;
        if (pm(w) == 2) return logic'(total % 2 == 1);
        return logic'(total % 2 == 0);
    endfunction

    function automatic logic ref_fe(input int w, input logic [1:0] st);
        if (ns(w) == 1) return ~st[0];
        return ~(st[0] & st[1]);
    endfunction

    function automatic logic [8:0] mask(input int w, input logic [8:0] d);
        return d & 9'((1 << nb(w)) - 1);
    endfunction

    task automatic hold(input int w, input logic v, input int n);
        case (w)
            0: rx_a = v;
            1: rx_b = v;
            default: rx_c = v;
        endcase
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input int w, input logic [8:0] d,
                              input logic pb, input logic [1:0] st);
        hold(w, 1'b0, CPB);
        for (int i = 0; i < nb(w); i++) hold(w, d[i], CPB);
        if (pm(w) != 0) hold(w, pb, CPB);
        for (int i = 0; i < ns(w); i++) hold(w, st[i], CPB);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if ({data_a, rdy_a, pe_a, fe_a, busy_a} !== 12'h0) begin
            errors++;
            $display("FAIL reset_a: got %h want 0", {data_a, rdy_a, pe_a, fe_a, busy_a});
        end
        checks++;
        if ({data_b, rdy_b, pe_b, fe_b, busy_b} !== 12'h0) begin
            errors++;
            $display("FAIL reset_b: got %h want 0", {data_b, rdy_b, pe_b, fe_b, busy_b});
        end
        checks++;
        if ({data_c, rdy_c, pe_c, fe_c, busy_c} !== 11'h0) begin
            errors++;
            $display("FAIL reset_c: got %h want 0", {data_c, rdy_c, pe_c, fe_c, busy_c});
        end
        reset_a = 1'b0;
        reset_b = 1'b0;
        reset_c = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_basic();
        rec_t r;
        clear_q(0);
        send_frame(0, 9'hA5, 1'b0, 2'b11);
        hold(0, 1'b1, 2 * CPB);
        checks++;
        if (qsize(0) != 1) begin
            errors++;
            $display("FAIL basic_count: got %0d want 1", qsize(0));
        end
        r = pop(0);
        checks++;
        if (r.data !== 9'hA5 || r.pe !== 1'b0 || r.fe !== 1'b0) begin
            errors++;
            $display("FAIL basic_word: got %h/%b/%b want a5/0/0", r.data, r.pe, r.fe);
        end
        checks++;
        if (r.busy !== 1'b0 || r.busy_prev !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_fall: got now=%b prev=%b want 0/1", r.busy, r.busy_prev);
        end
    endtask

    task automatic test_parity();
        rec_t r;
        logic pb;
        clear_q(1);
        for (int k = 0; k < 2; k++) begin
            pb = (k == 0) ? 1'b1 : 1'b0;
            send_frame(1, 9'h03, pb, 2'b11);
            hold(1, 1'b1, 2 * CPB);
        end
        checks++;
        if (qsize(1) != 2) begin
            errors++;
            $display("FAIL parity_count: got %0d want 2", qsize(1));
        end
        for (int k = 0; k < 2; k++) begin
            pb = (k == 0) ? 1'b1 : 1'b0;
            r = pop(1);
            checks++;
            if (r.data !== 9'h03 || r.pe !== ref_pe(1, 9'h03, pb) || r.fe !== 1'b0) begin
                errors++;
                $display("FAIL parity_word%0d: got %h/%b/%b want 03/%b/0",
                         k, r.data, r.pe, r.fe, ref_pe(1, 9'h03, pb));
            end
        end
    endtask

    task automatic test_break();
        rec_t r;
        clear_q(0);
        send_frame(0, 9'h55, 1'b0, 2'b00);
        hold(0, 1'b0, 40 * CPB);
        checks++;
        if (qsize(0) != 1) begin
            errors++;
            $display("FAIL break_hold_count: got %0d want 1", qsize(0));
        end
        hold(0, 1'b1, 2 * CPB);
        send_frame(0, 9'h3C, 1'b0, 2'b11);
        hold(0, 1'b1, 2 * CPB);
        r = pop(0);
        checks++;
        if (r.data !== 9'h55 || r.fe !== 1'b1 || r.pe !== 1'b0) begin
            errors++;
            $display("FAIL break_first: got %h/fe=%b want 55/fe=1", r.data, r.fe);
        end
        checks++;
        if (qsize(0) != 1) begin
            errors++;
            $display("FAIL break_second_count: got %0d want 1", qsize(0));
        end
        r = pop(0);
        checks++;
        if (r.data !== 9'h3C || r.fe !== 1'b0) begin
            errors++;
            $display("FAIL break_second: got %h/fe=%b want 3c/fe=0", r.data, r.fe);
        end
    endtask

    task automatic test_glitch();
        logic [7:0] old;
        logic       saw_busy;
        old = data_a;
        saw_busy = 1'b0;
        clear_q(0);
        hold(0, 1'b0, 5);
        rx_a = 1'b1;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge clock);
            saw_busy |= busy_a;
        end
        checks++;
        if (saw_busy !== 1'b1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy: got seen=%b end=%b want 1/0", saw_busy, busy_a);
        end
        checks++;
        if (qsize(0) != 0 || data_a !== old) begin
            errors++;
            $display("FAIL glitch_output: got pulses=%0d data=%h want 0/%h",
                     qsize(0), data_a, old);
        end
    endtask

    task automatic test_back_to_back();
        rec_t r0, r1;
        clear_q(0);
        send_frame(0, 9'h00, 1'b0, 2'b11);
        send_frame(0, 9'hFF, 1'b0, 2'b11);
        hold(0, 1'b1, 2 * CPB);
        checks++;
        if (qsize(0) != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 2", qsize(0));
        end
        r0 = pop(0);
        r1 = pop(0);
        checks++;
        if (r0.data !== 9'h00 || r1.data !== 9'hFF) begin
            errors++;
            $display("FAIL b2b_data: got %h,%h want 00,ff", r0.data, r1.data);
        end
        checks++;
        if (r1.cyc - r0.cyc < 10 * CPB - 1 || r1.cyc - r0.cyc > 10 * CPB + 1) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d want %0d+-1", r1.cyc - r0.cyc, 10 * CPB);
        end
    endtask

    task automatic test_reset_mid();
        rec_t r;
        logic [8:0] d;
        clear_q(2);
        d = 9'h41;
        send_frame(2, d, good_pbit(2, d), 2'b11);
        hold(2, 1'b1, 2 * CPB);
        send_frame(2, d, good_pbit(2, d), 2'b01);
        hold(2, 1'b1, 2 * CPB);
        checks++;
        if (qsize(2) != 2) begin
            errors++;
            $display("FAIL c_count: got %0d want 2", qsize(2));
        end
        r = pop(2);
        checks++;
        if (r.data !== 9'h41 || r.pe !== 1'b0 || r.fe !== 1'b0) begin
            errors++;
            $display("FAIL c_good: got %h/%b/%b want 41/0/0", r.data, r.pe, r.fe);
        end
        r = pop(2);
        checks++;
        if (r.data !== 9'h41 || r.pe !== 1'b0 || r.fe !== 1'b1) begin
            errors++;
            $display("FAIL c_stop2: got %h/%b/%b want 41/0/1", r.data, r.pe, r.fe);
        end
        d = 9'h2A;
        hold(2, 1'b0, CPB);
        for (int i = 0; i < 3; i++) hold(2, d[i], CPB);
        hold(2, d[3], CPB / 2);
        reset_c = 1'b1;
        rx_c = 1'b1;
        @(negedge clock);
        checks++;
        if ({data_c, rdy_c, pe_c, fe_c, busy_c} !== 11'h0) begin
            errors++;
            $display("FAIL c_reset_mid: got %h want 0", {data_c, rdy_c, pe_c, fe_c, busy_c});
        end
        @(negedge clock);
        reset_c = 1'b0;
        hold(2, 1'b1, 2 * CPB);
        checks++;
        if (qsize(2) != 0) begin
            errors++;
            $display("FAIL c_after_reset_pulses: got %0d want 0", qsize(2));
        end
        d = 9'h41;
        send_frame(2, d, good_pbit(2, d), 2'b11);
        hold(2, 1'b1, 2 * CPB);
        r = pop(2);
        checks++;
        if (r.data !== 9'h41 || r.pe !== 1'b0 || r.fe !== 1'b0) begin
            errors++;
            $display("FAIL c_after_reset_word: got %h/%b/%b want 41/0/0", r.data, r.pe, r.fe);
        end
    endtask

    task automatic test_random(input int w);
        exp_t       exp_q[$];
        exp_t       e;
        rec_t       r;
        logic [8:0] d;
        logic       pb;
        logic [1:0] st;
        int         gap;
        clear_q(w);
        for (int k = 0; k < 8; k++) begin
            d  = mask(w, 9'($urandom));
            pb = good_pbit(w, d) ^ logic'($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            exp_q.push_back('{d, ref_pe(w, d, pb), ref_fe(w, st)});
            send_frame(w, d, pb, st);
            gap = $urandom_range(0, 20);
            if (st[ns(w) - 1] == 1'b0) gap += CPB;
            if (gap > 0) hold(w, 1'b1, gap);
        end
        hold(w, 1'b1, 2 * CPB);
        checks++;
        if (qsize(w) != 8) begin
            errors++;
            $display("FAIL rand%0d_count: got %0d want 8", w, qsize(w));
        end
        for (int k = 0; k < 8; k++) begin
            e = exp_q.pop_front();
            r = pop(w);
            checks++;
            if (r.data !== e.data || r.pe !== e.pe || r.fe !== e.fe) begin
                errors++;
                $display("FAIL rand%0d_word%0d: got %h/%b/%b want %h/%b/%b",
                         w, k, r.data, r.pe, r.fe, e.data, e.pe, e.fe);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_break();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        for (int w = 0; w < 3; w++) test_random(w);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
